// File: rtl/controller_sequencer_if.sv
// Control-word bundle between the sequencer and the 8-bit datapath.
// The master (sequencer) reads the IR opcode and drives every control line
// plus the T-state ring. The slave (datapath) supplies the opcode and
// consumes the controls.
interface controller_sequencer_if #(
   parameter int OPW = 4
);
   logic [OPW-1:0] opcode;
   logic           cp;
   logic           ep;
   logic           lm;
   logic           ce;
   logic           li;
   logic           ei;
   logic           la;
   logic           ea;
   logic           su;
   logic           eu;
   logic           lb;
   logic           lo;
   logic           hlt;
   logic [5:0]     tstate;

   modport master (
      input  opcode,
      output cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, hlt, tstate
   );

   modport slave (
      output opcode,
      input  cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, hlt, tstate
   );
endinterface

// File: rtl/controller_sequencer.sv
// Six-state one-hot ring counter (T1..T6) with the opcode decoder.
// T1-T3 fetch the instruction. T4-T6 execute LDA/ADD/SUB/OUT, and any
// other opcode is a NOP.
// Optional feature macro: CTRL_HALT_EN. When it is defined, opcode 1111
// halts the machine in T4 until clr. When it is undefined, 1111 is a NOP
// and hlt is tied to 0.
module controller_sequencer #(
   parameter int OPW = 4
) (
   input  logic                      clk,
   input  logic                      clr,
   controller_sequencer_if.master    bus
);

   typedef enum logic [5:0] {
      T1 = 6'b000001,
      T2 = 6'b000010,
      T3 = 6'b000100,
      T4 = 6'b001000,
      T5 = 6'b010000,
      T6 = 6'b100000
   } tstate_e;

   typedef struct packed {
      logic cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, hlt;
   } ctrl_t;

   localparam logic [OPW-1:0] OP_LDA = OPW'(4'b0000);
   localparam logic [OPW-1:0] OP_ADD = OPW'(4'b0001);
   localparam logic [OPW-1:0] OP_SUB = OPW'(4'b0010);
   localparam logic [OPW-1:0] OP_OUT = OPW'(4'b1110);
   localparam logic [OPW-1:0] OP_HLT = OPW'(4'b1111);

   tstate_e state_q;
   tstate_e state_d;
   logic    run_q;     // low only until the first edge after clr, which holds T1
   logic    halted_q;
   ctrl_t   ctrl;

`ifdef CTRL_HALT_EN
   localparam bit HALT_EN = 1'b1;

   // Sticky halt flag: set when T4 is left with HLT decoded, cleared only by clr.
   always_ff @(posedge clk or posedge clr) begin
      if (clr)
         halted_q <= 1'b0;
      else if (state_q == T4 && bus.opcode == OP_HLT)
         halted_q <= 1'b1;
   end
`else
   localparam bit HALT_EN = 1'b0;
   assign halted_q = 1'b0;
`endif

   // Ring-counter register. The first edge after reset release keeps T1.
   always_ff @(posedge clk or posedge clr) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (clr) begin
         state_q <= T1;
         run_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         run_q   <= 1'b1;
      end
   end

   // Next-state and control-word decode from the registered T-state and the live opcode.
   always_comb begin
      // NOTE: defaults come first so no path leaves an output unassigned (no latches).
      ctrl    = '0;
      state_d = T1;
      case (state_q)
         T1: begin
            ctrl.ep = 1'b1;
            ctrl.lm = 1'b1;
            state_d = T2;
         end
         T2: begin
            ctrl.cp = 1'b1;
            state_d = T3;
         end
         T3: begin
            ctrl.ce = 1'b1;
            ctrl.li = 1'b1;
            state_d = T4;
         end
         T4: begin
            state_d = T5;
            if (HALT_EN && bus.opcode == OP_HLT) begin
               ctrl.hlt = 1'b1;
               state_d  = T4;
            end else begin
               case (bus.opcode)
                  OP_LDA, OP_ADD, OP_SUB: begin
                     ctrl.ei = 1'b1;
                     ctrl.lm = 1'b1;
                  end
                  OP_OUT: begin
                     ctrl.ea = 1'b1;
                     ctrl.lo = 1'b1;
                  end
                  default: ;
               endcase
            end
         end
         T5: begin
            state_d = T6;
            case (bus.opcode)
               OP_LDA: begin
                  ctrl.ce = 1'b1;
                  ctrl.la = 1'b1;
               end
               OP_ADD: begin
                  ctrl.ce = 1'b1;
                  ctrl.lb = 1'b1;
               end
               OP_SUB: begin
                  // su rises a state early so the difference settles before eu.
                  ctrl.ce = 1'b1;
                  ctrl.lb = 1'b1;
                  ctrl.su = 1'b1;
               end
               default: ;
            endcase
         end
         T6: begin
            state_d = T1;
            case (bus.opcode)
               OP_ADD: begin
                  ctrl.eu = 1'b1;
                  ctrl.la = 1'b1;
               end
               OP_SUB: begin
                  ctrl.eu = 1'b1;
                  ctrl.la = 1'b1;
                  ctrl.su = 1'b1;
               end
               default: ;
            endcase
         end
         // A corrupted ring (zero or several bits set) drives nothing and restarts at T1.
         default: begin
            ctrl    = '0;
            state_d = T1;
         end
      endcase

      if (!run_q)
         state_d = T1;

      if (halted_q) begin
         ctrl     = '0;
         ctrl.hlt = 1'b1;
         state_d  = T4;
      end

      if (clr)
         ctrl = '0;
   end

   assign bus.cp     = ctrl.cp;
   assign bus.ep     = ctrl.ep;
   assign bus.lm     = ctrl.lm;
   assign bus.ce     = ctrl.ce;
   assign bus.li     = ctrl.li;
   assign bus.ei     = ctrl.ei;
   assign bus.la     = ctrl.la;
   assign bus.ea     = ctrl.ea;
   assign bus.su     = ctrl.su;
   assign bus.eu     = ctrl.eu;
   assign bus.lb     = ctrl.lb;
   assign bus.lo     = ctrl.lo;
   assign bus.hlt    = ctrl.hlt;
   assign bus.tstate = state_q;

endmodule

// File: tb/tb_controller_sequencer.sv
// Scoreboard bench for controller_sequencer.
// The stimulus side steps a microcode-ROM reference model and queues the
// expected (tstate, control word) for every sample point. A separate monitor
// pops each entry and compares it with the DUT. A third process watches the
// bus-exclusivity and one-hot invariants every cycle.
module tb_controller_sequencer;

`ifdef CTRL_HALT_EN
   localparam bit HALT_EN = 1'b1;
`else
   localparam bit HALT_EN = 1'b0;
`endif

   // Bit positions inside the 13-bit control word.
   localparam int CP = 12, EP = 11, LM = 10, CE = 9, LI = 8, EI = 7, LA = 6;
   localparam int EA = 5, SU = 4, EU = 3, LB = 2, LO = 1, HLT = 0;

   typedef struct packed {
      logic [5:0]  tstate;
      logic [12:0] ctrl;
   } exp_t;

   logic clk = 1'b0;
   logic clr;

   controller_sequencer_if #(.OPW(4)) bus_if();

   controller_sequencer #(.OPW(4)) dut (
      .clk (clk),
      .clr (clr),
      .bus (bus_if.master)
   );

   always #5 clk = ~clk;

   int   n_checks = 0;
   int   n_errors = 0;
   exp_t exp_q[$];
   event sample_ev;

   // Microcode ROM model: three fetch words, then three execute words per opcode.
   logic [12:0] fetch_rom[3];
   logic [12:0] exec_rom[16][3];

   // Abstract machine state: position within the instruction (0..5),
   // the post-reset hold edge, and the halt latch.
   int m_step;
   bit m_hold;
   bit m_halted;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0h required %0h", name, $time, act, req);
      end
   endtask

   function automatic logic [12:0] dut_ctrl();
      return {bus_if.cp, bus_if.ep, bus_if.lm, bus_if.ce, bus_if.li, bus_if.ei,
              bus_if.la, bus_if.ea, bus_if.su, bus_if.eu, bus_if.lb, bus_if.lo,
              bus_if.hlt};
   endfunction

   function automatic logic [12:0] bit_of(input int pos);
      logic [12:0] w;
      w = '0;
      w[pos] = 1'b1;
      return w;
   endfunction

   function automatic exp_t model_expect(input logic clr_v, input logic [3:0] op);
      exp_t e;
      e.tstate = 6'b000001;
      e.ctrl   = '0;
      if (clr_v) begin
         e.tstate = 6'b000001;
      end else if (m_halted) begin
         e.tstate = 6'b001000;
         e.ctrl   = bit_of(HLT);
      end else if (HALT_EN && m_step == 3 && op == 4'hF) begin
         e.tstate = 6'b001000;
         e.ctrl   = bit_of(HLT);
      end else begin
         e.tstate = 6'(1 << m_step);
         e.ctrl   = (m_step < 3) ? fetch_rom[m_step] : exec_rom[op][m_step - 3];
      end
      return e;
   endfunction

   task automatic model_reset();
      m_step   = 0;
      m_hold   = 1'b1;
      m_halted = 1'b0;
   endtask

   task automatic model_edge(input logic [3:0] op);
      if (m_hold)
         m_hold = 1'b0;
      else if (m_halted)
         m_halted = 1'b1;
      else if (HALT_EN && m_step == 3 && op == 4'hF)
         m_halted = 1'b1;
      else
         m_step = (m_step + 1) % 6;
   endtask

   // One clock of stimulus: drive at the falling edge, queue the expectation, advance the model at the rising edge.
   task automatic cycle(input logic [3:0] op, input logic c);
      @(negedge clk);
      bus_if.opcode = op;
      clr = c;
      if (c)
         model_reset();
      exp_q.push_back(model_expect(c, op));
      #1 -> sample_ev;
      @(posedge clk);
      if (!clr)
         model_edge(op);
   endtask

   // Raise clr between edges, away from any clock edge.
   task automatic async_clr();
      #2;
      clr = 1'b1;
      model_reset();
      exp_q.push_back(model_expect(1'b1, bus_if.opcode));
      #1 -> sample_ev;
   endtask

   task automatic run_instr(input logic [3:0] op);
      repeat (6) cycle(op, 1'b0);
   endtask

   // Scoreboard monitor: compare every queued expectation with the DUT.
   initial begin
      exp_t e;
      forever begin
         @(sample_ev);
         if (exp_q.size() == 0) begin
            check("queue_underflow", 32'd0, 32'd1);
         end else begin
            e = exp_q.pop_front();
            check("tstate", 32'(bus_if.tstate), 32'(e.tstate));
            check("ctrl_word", 32'(dut_ctrl()), 32'(e.ctrl));
         end
      end
   end

   // Invariant watcher: at most one bus driver, and a one-hot ring, every cycle.
   initial begin
      forever begin
         @(negedge clk);
         #3;
         check("bus_exclusive",
               32'($countones({bus_if.ep, bus_if.ce, bus_if.ei, bus_if.ea, bus_if.eu}) <= 1),
               32'd1);
         check("tstate_onehot", 32'($onehot(bus_if.tstate)), 32'd1);
      end
   end

   initial begin
      logic [3:0] op;
      logic       c;
      int         guard;

      foreach (exec_rom[i, j]) exec_rom[i][j] = '0;
      fetch_rom[0] = bit_of(EP) | bit_of(LM);
      fetch_rom[1] = bit_of(CP);
      fetch_rom[2] = bit_of(CE) | bit_of(LI);
      exec_rom[4'b0000][0] = bit_of(EI) | bit_of(LM);
      exec_rom[4'b0000][1] = bit_of(CE) | bit_of(LA);
      exec_rom[4'b0001][0] = bit_of(EI) | bit_of(LM);
      exec_rom[4'b0001][1] = bit_of(CE) | bit_of(LB);
      exec_rom[4'b0001][2] = bit_of(EU) | bit_of(LA);
      exec_rom[4'b0010][0] = bit_of(EI) | bit_of(LM);
      exec_rom[4'b0010][1] = bit_of(CE) | bit_of(LB) | bit_of(SU);
      exec_rom[4'b0010][2] = bit_of(EU) | bit_of(LA) | bit_of(SU);
      exec_rom[4'b1110][0] = bit_of(EA) | bit_of(LO);

      clr = 1'b1;
      bus_if.opcode = 4'h0;
      model_reset();

      // Reset state, then release: one hold edge in T1, then the normal sequence.
      cycle(4'h0, 1'b1);
      cycle(4'h0, 1'b1);
      cycle(4'h0, 1'b0);

      // One instruction of each kind, including a NOP opcode.
      run_instr(4'b0000);
      run_instr(4'b0001);
      run_instr(4'b0010);
      run_instr(4'b1110);
      run_instr(4'b0101);

      // HLT: reach T4, then 20 more cycles, then a clr pulse.
      repeat (24) cycle(4'hF, 1'b0);
      cycle(4'hF, 1'b1);
      cycle(4'h1, 1'b0);
      run_instr(4'h1);

      // Opcode changing every cycle during execute.
      for (int i = 0; i < 12; i++)
         cycle(4'($urandom_range(0, 14)), 1'b0);

      // Asynchronous clr in the middle of T5 of a SUB.
      guard = 0;
      while (m_step != 4 && guard < 20) begin
         cycle(4'b0010, 1'b0);
         guard++;
      end
      check("reach_t5", 32'(m_step), 32'd4);
      async_clr();
      cycle(4'b0010, 1'b1);
      cycle(4'b0010, 1'b0);
      run_instr(4'b0010);

      // Random instructions with occasional clr pulses and occasional mid-execute opcode changes.
      for (int i = 0; i < 200; i++) begin
         op = 4'($urandom_range(0, 15));
         for (int k = 0; k < 6; k++) begin
            c = ($urandom_range(0, 39) == 0);
            if (m_halted && $urandom_range(0, 3) == 0)
               c = 1'b1;
            if ($urandom_range(0, 7) == 0)
               op = 4'($urandom_range(0, 15));
            cycle(op, c);
         end
      end
      cycle(4'h0, 1'b1);

      guard = 0;
      while (exp_q.size() != 0 && guard < 10) begin
         @(negedge clk);
         guard++;
      end
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
